ysyx_22040365_ifu: RTL

- Instruction fetch unit: owns the PC and issues instruction reads to memory.
- Extracts the 32-bit instruction word from the memory response.
- Presents the instruction, with its PC, to decode over a valid/ready handshake.
- It is the producer of the `inst` value that the core top-level (id/regfile/ex) consumes, and accepts PC redirects from execute.

---
 rtl/ysyx_22040365_ifu_if.sv | 31 +++
 rtl/ysyx_22040365_ifu.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040365_ifu_if.sv
// Fetch-unit bus bundle: memory request/response, the instruction handoff to decode, and the execute redirect.
// Ports: master = fetch unit (drives the request and the instruction), slave = environment (memory, decode, execute).
// Widths follow ADDR_W (PC/address) and MEM_DW (memory data); they must match the fetch unit's parameters.
interface ysyx_22040365_ifu_if #(
    parameter int ADDR_W = 64,
    parameter int MEM_DW = 64
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [MEM_DW-1:0] mem_resp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: owns the PC, issues one memory read at a time, hands the 32-bit word plus its PC to decode.
// Latency: request accepted cycle N, response N+1, inst_valid N+2; a zero-wait memory gives one instruction per 3 cycles.
// Backpressure: the instruction is held stable until decode takes it; no new request is issued while it is held.
// Ports: clk, rst (synchronous, active-low), bus (ysyx_22040365_ifu_if.master).
// Optional: define YSYX_22040365_IFU_MISALIGN_EN to add output fetch_misalign and a FAULT state on misaligned redirects.
module ysyx_22040365_ifu #(
    parameter int                ADDR_W   = 64,
    parameter int                MEM_DW   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h0000_0000_8000_0000)
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_22040365_ifu_if.master        bus
`ifdef YSYX_22040365_IFU_MISALIGN_EN
    ,
    output logic                       fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
`ifdef YSYX_22040365_IFU_MISALIGN_EN
        ,
        ST_FAULT = 2'd3
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       resp_word;
    logic              drop_q, drop_d;
    logic              req_vld_q, req_vld_d;
    logic              inst_vld_q, inst_vld_d;
    logic              req_fire;
    logic              redir_ok;

    assign req_fire = req_vld_q & bus.mem_req_ready;

`ifdef YSYX_22040365_IFU_MISALIGN_EN
    logic misalign_q, misalign_d;
    logic redir_bad;

    assign redir_bad      = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    assign redir_ok       = bus.redirect_valid & ~redir_bad;
    assign fetch_misalign = misalign_q;
`else
    // Low PC bits are not checked here; the word select below only looks at pc[2].
    assign redir_ok = bus.redirect_valid;
`endif

    // A 64-bit memory returns the whole aligned doubleword; pc[2] picks the half.
    generate
        if (MEM_DW == 64) begin : g_dw64
            assign bus.mem_req_addr = {pc_q[ADDR_W-1:3], 3'b000};
            assign resp_word        = pc_q[2] ? bus.mem_resp_data[63:32] : bus.mem_resp_data[31:0];
        end else begin : g_dw32
            assign bus.mem_req_addr = pc_q;
            assign resp_word        = bus.mem_resp_data[31:0];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        inst_vld_d = inst_vld_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
`ifdef YSYX_22040365_IFU_MISALIGN_EN
        misalign_d = 1'b0;
`endif

        case (state_q)
            ST_REQ: begin
                // A request accepted together with a redirect fetches the stale
                // address, so its response must be thrown away.
                if (req_fire) begin
                    state_d = ST_WAIT;
                    drop_d  = redir_ok;
                end
                if (redir_ok) begin
                    pc_d = bus.redirect_pc;
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (drop_q || redir_ok) begin
                        state_d = ST_REQ;
                        drop_d  = 1'b0;
                        if (redir_ok) begin
                            pc_d = bus.redirect_pc;
                        end
                    end else begin
                        inst_d     = resp_word;
                        inst_pc_d  = pc_q;
                        inst_vld_d = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end else if (redir_ok) begin
                    drop_d = 1'b1;
                    pc_d   = bus.redirect_pc;
                end
            end
            ST_HOLD: begin
                // Redirect wins over a same-cycle decode handshake.
                if (redir_ok) begin
                    pc_d       = bus.redirect_pc;
                    inst_vld_d = 1'b0;
                    state_d    = ST_REQ;
                end else if (bus.inst_ready) begin
                    pc_d       = pc_q + ADDR_W'(4);
                    inst_vld_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
`ifdef YSYX_22040365_IFU_MISALIGN_EN
            ST_FAULT: begin
                if (redir_ok) begin
                    pc_d    = bus.redirect_pc;
                    state_d = ST_REQ;
                end
            end
`endif
            default: begin
                state_d = ST_REQ;
            end
        endcase

`ifdef YSYX_22040365_IFU_MISALIGN_EN
        // A misaligned target parks the unit from any state; any response
        // still in flight is simply ignored since FAULT is not WAIT.
        if (redir_bad) begin
            pc_d       = bus.redirect_pc;
            state_d    = ST_FAULT;
            drop_d     = 1'b0;
            inst_vld_d = 1'b0;
        end
        misalign_d = (state_d == ST_FAULT);
`endif

        // Registered request valid: it is low on the first cycle after reset
        // and tracks the state being REQ thereafter.
        req_vld_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            req_vld_q  <= 1'b0;
            inst_vld_q <= 1'b0;
            inst_q     <= 32'h0;
            inst_pc_q  <= RESET_PC;
`ifdef YSYX_22040365_IFU_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            req_vld_q  <= req_vld_d;
            inst_vld_q <= inst_vld_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
`ifdef YSYX_22040365_IFU_MISALIGN_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign bus.mem_req_valid = req_vld_q;
    assign bus.inst_valid    = inst_vld_q;
    assign bus.inst          = inst_q;
    assign bus.inst_pc       = inst_pc_q;

endmodule
